// File: rtl/thor2023_icmiss_ctrl_if.sv
// Memory read bus between the I-cache miss controller and the fill source.
interface thor2023_icmiss_ctrl_if #(
   parameter int unsigned AWID = 32
) ();
   logic            mem_req;
   logic [AWID-1:0] mem_adr;
   logic            mem_ack;
   logic            mem_err;
   logic [127:0]    mem_dat;

   modport master (
      output mem_req, mem_adr,
      input  mem_ack, mem_err, mem_dat
   );

   modport slave (
      input  mem_req, mem_adr,
      output mem_ack, mem_err, mem_dat
   );
endinterface

// File: rtl/thor2023_icmiss_ctrl.sv
// I-cache miss controller: victim selection, four-beat line fill, valid-bit
// bookkeeping and deferred invalidation while a fill is in flight.
module thor2023_icmiss_ctrl #(
   parameter int unsigned LINES  = 256,
   parameter int unsigned WAYS   = 4,
   parameter int unsigned AWID   = 32,
   parameter int unsigned TAGBIT = 14,
   parameter int unsigned BEATS  = 4
) (
   input  logic                          rst,
   input  logic                          clk,
   input  logic [AWID-1:0]               ip,
   input  logic                          fetch,
   input  logic                          ihit,
   input  logic                          inv_all,
   input  logic                          inv_line,
   input  logic [AWID-1:0]               inv_adr,
   thor2023_icmiss_ctrl_if.master        bus,
   output logic                          wr_en,
   output logic [1:0]                    wr_way,
   output logic [$clog2(LINES)-1:0]      wr_ndx,
   output logic [1:0]                    wr_beat,
   output logic [127:0]                  wr_dat,
   output logic                          tag_wr,
   output logic [LINES-1:0][WAYS-1:0]    valid,
   output logic                          stall,
   output logic                          fault
);

   localparam int unsigned NDXW = $clog2(LINES);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

   state_t            state;
   logic [AWID-7:0]   line_q;
   logic [NDXW-1:0]   ndx_q;
   logic [1:0]        victim_q;
   logic [1:0]        rr_q;
   logic [1:0]        beat_q;
   logic              pend_all;
   logic              pend_line;
   logic [NDXW-1:0]   pend_ndx;
   logic              mem_req_q;
   logic [AWID-1:0]   mem_adr_q;

   logic [NDXW-1:0]   ip_ndx_c;
   logic [NDXW-1:0]   inv_ndx_c;
   logic              inv_any_c;
   logic              miss_c;
   logic [1:0]        victim_c;
   logic              found_c;
   logic              unused_c;

   assign ip_ndx_c  = ip[TAGBIT-1:6];
   assign inv_ndx_c = inv_adr[TAGBIT-1:6];
   assign unused_c  = ^{ip[5:0], inv_adr[AWID-1:TAGBIT], inv_adr[5:0]};

   // Any invalidate (live or deferred) outranks starting a miss this cycle.
   assign inv_any_c = inv_all | inv_line | pend_all | pend_line;
   assign miss_c    = (state == IDLE) & fetch & ~ihit & ~inv_any_c;

   // Victim: lowest invalid way of the fetch set, else the round-robin way.
   always_comb begin
      victim_c = rr_q;
      found_c  = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found_c && !valid[ip_ndx_c][w]) begin
            victim_c = 2'(w);
            found_c  = 1'b1;
         end
      end
   end

   // Beat data is written to the data array in the same cycle it is acked.
   assign wr_en   = (state == WAIT) & bus.mem_ack & ~bus.mem_err;
   assign wr_way  = victim_q;
   assign wr_ndx  = ndx_q;
   assign wr_beat = beat_q;
   assign wr_dat  = bus.mem_dat;

   assign bus.mem_req = mem_req_q;
   assign bus.mem_adr = mem_adr_q;

   // Fetch waits on a miss in IDLE and for the whole fill; never during reset.
   assign stall = ~rst & ((state != IDLE) | (fetch & ~ihit));

   // Fill sequencer, valid array and deferred-invalidate bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         line_q    <= '0;
         ndx_q     <= '0;
         victim_q  <= '0;
         rr_q      <= '0;
         beat_q    <= '0;
         pend_all  <= 1'b0;
         pend_line <= 1'b0;
         pend_ndx  <= '0;
         mem_req_q <= 1'b0;
         mem_adr_q <= '0;
         tag_wr    <= 1'b0;
         fault     <= 1'b0;
         valid     <= '0;
      end else begin
         tag_wr <= 1'b0;
         fault  <= 1'b0;
         case (state)
            IDLE: begin
               if (inv_all | pend_all) begin
                  valid <= '0;
               end else begin
                  if (inv_line)  valid[inv_ndx_c] <= '0;
                  if (pend_line) valid[pend_ndx]  <= '0;
               end
               pend_all  <= 1'b0;
               pend_line <= 1'b0;
               if (miss_c) begin
                  line_q                    <= ip[AWID-1:6];
                  ndx_q                     <= ip_ndx_c;
                  victim_q                  <= victim_c;
                  beat_q                    <= '0;
                  valid[ip_ndx_c][victim_c] <= 1'b0;
                  tag_wr                    <= 1'b1;
                  state                     <= REQ;
               end
            end
            REQ: begin
               mem_req_q <= 1'b1;
               mem_adr_q <= {line_q, beat_q, 4'h0};
               state     <= WAIT;
            end
            WAIT: begin
               if (bus.mem_ack) begin
                  mem_req_q <= 1'b0;
                  if (bus.mem_err) begin
                     fault  <= 1'b1;
                     beat_q <= '0;
                     state  <= IDLE;
                  end else if (beat_q == 2'(BEATS - 1)) begin
                     state <= FIN;
                  end else begin
                     beat_q <= beat_q + 2'd1;
                     state  <= REQ;
                  end
               end
            end
            FIN: begin
               valid[ndx_q][victim_q] <= 1'b1;
               rr_q                   <= rr_q + 2'd1;
               beat_q                 <= '0;
               state                  <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (state != IDLE) begin
            if (inv_all) pend_all <= 1'b1;
            if (inv_line) begin
               pend_line <= 1'b1;
               pend_ndx  <= inv_ndx_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_thor2023_icmiss_ctrl.sv
// Bench for the I-cache miss controller: directed scenarios plus random
// misses, hits and invalidates against a set/way occupancy model.
module tb_thor2023_icmiss_ctrl;
   localparam int unsigned LINES  = 256;
   localparam int unsigned WAYS   = 4;
   localparam int unsigned AWID   = 32;
   localparam int unsigned TAGBIT = 14;
   localparam int unsigned BEATS  = 4;

   logic                     clk;
   logic                     rst;
   logic [AWID-1:0]          ip;
   logic                     fetch;
   logic                     ihit;
   logic                     inv_all;
   logic                     inv_line;
   logic [AWID-1:0]          inv_adr;
   logic                     wr_en;
   logic [1:0]               wr_way;
   logic [$clog2(LINES)-1:0] wr_ndx;
   logic [1:0]               wr_beat;
   logic [127:0]             wr_dat;
   logic                     tag_wr;
   logic [LINES-1:0][WAYS-1:0] valid;
   logic                     stall;
   logic                     fault;

   thor2023_icmiss_ctrl_if #(.AWID(AWID)) bus ();

   thor2023_icmiss_ctrl #(
      .LINES(LINES), .WAYS(WAYS), .AWID(AWID), .TAGBIT(TAGBIT), .BEATS(BEATS)
   ) dut (
      .rst(rst), .clk(clk), .ip(ip), .fetch(fetch), .ihit(ihit),
      .inv_all(inv_all), .inv_line(inv_line), .inv_adr(inv_adr),
      .bus(bus), .wr_en(wr_en), .wr_way(wr_way), .wr_ndx(wr_ndx),
      .wr_beat(wr_beat), .wr_dat(wr_dat), .tag_wr(tag_wr), .valid(valid),
      .stall(stall), .fault(fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   // Reference state: occupancy per set/way, replacement pointer, deferred invalidates.
   bit vm [LINES][WAYS];
   int rr_m;
   bit p_all;
   bit p_line;
   int p_ndx;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   function automatic int m_victim(input int ndx);
      for (int w = 0; w < WAYS; w++)
         if (!vm[ndx][w]) return w;
      return rr_m;
   endfunction

   task automatic m_clear_all();
      for (int l = 0; l < LINES; l++)
         for (int w = 0; w < WAYS; w++)
            vm[l][w] = 1'b0;
   endtask

   task automatic m_clear_set(input int ndx);
      for (int w = 0; w < WAYS; w++) vm[ndx][w] = 1'b0;
   endtask

   task automatic m_apply_pending();
      if (p_all) m_clear_all();
      else if (p_line) m_clear_set(p_ndx);
      p_all  = 1'b0;
      p_line = 1'b0;
   endtask

   task automatic check_valid(input string tag);
      int diff;
      diff = 0;
      for (int l = 0; l < LINES; l++)
         for (int w = 0; w < WAYS; w++)
            if (valid[l][w] !== vm[l][w]) diff++;
      check(tag, 128'(diff), 128'(0));
   endtask

   // Full miss starting in IDLE; ends one cycle after returning to IDLE.
   task automatic run_miss(input logic [31:0] a, input int err_beat, input int max_wait,
                           input int inv_kind, input logic [31:0] inv_a);
      int ndx;
      int vw;
      int waits;
      bit errd;
      logic [127:0] d;
      ndx  = int'(a[TAGBIT-1:6]);
      vw   = m_victim(ndx);
      errd = 1'b0;
      ip = a; fetch = 1'b1; ihit = 1'b0;
      #1;
      check("miss_stall", 128'(stall), 128'(1));
      check("idle_tag_wr", 128'(tag_wr), 128'(0));
      check("idle_mem_req", 128'(bus.mem_req), 128'(0));
      @(negedge clk);
      fetch = 1'b0;
      vm[ndx][vw] = 1'b0;
      #1;
      check("tag_wr", 128'(tag_wr), 128'(1));
      check("tag_way", 128'(wr_way), 128'(vw));
      check("tag_ndx", 128'(wr_ndx), 128'(ndx));
      check("req_mem_req", 128'(bus.mem_req), 128'(0));
      check("fill_stall", 128'(stall), 128'(1));
      check("victim_cleared", 128'(valid[ndx][vw]), 128'(0));
      @(negedge clk);
      for (int b = 0; b < BEATS && !errd; b++) begin
         waits = int'($urandom_range(max_wait));
         for (int w = 0; w <= waits; w++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            bus.mem_ack = (w == waits);
            bus.mem_err = (w == waits) && (b == err_beat);
            bus.mem_dat = d;
            if (b == 0 && w == 0 && inv_kind != 0) begin
               inv_all  = (inv_kind == 1);
               inv_line = (inv_kind == 2);
               inv_adr  = inv_a;
               if (inv_kind == 1) p_all = 1'b1;
               else begin
                  p_line = 1'b1;
                  p_ndx  = int'(inv_a[TAGBIT-1:6]);
               end
            end
            #1;
            check("wait_mem_req", 128'(bus.mem_req), 128'(1));
            check("mem_adr", 128'(bus.mem_adr), 128'({a[AWID-1:6], 2'(b), 4'h0}));
            check("wait_tag_wr", 128'(tag_wr), 128'(0));
            if (w == waits) begin
               if (b == err_beat) begin
                  check("err_wr_en", 128'(wr_en), 128'(0));
                  errd = 1'b1;
               end else begin
                  check("wr_en", 128'(wr_en), 128'(1));
                  check("wr_dat", wr_dat, d);
                  check("wr_beat", 128'(wr_beat), 128'(b));
                  check("wr_way", 128'(wr_way), 128'(vw));
                  check("wr_ndx", 128'(wr_ndx), 128'(ndx));
               end
            end else begin
               check("wait_wr_en", 128'(wr_en), 128'(0));
            end
            @(negedge clk);
            bus.mem_ack = 1'b0; bus.mem_err = 1'b0;
            inv_all = 1'b0; inv_line = 1'b0;
         end
         if (!errd) begin
            #1;
            check("gap_mem_req", 128'(bus.mem_req), 128'(0));
            check("gap_stall", 128'(stall), 128'(1));
            check("gap_valid", 128'(valid[ndx][vw]), 128'(0));
            @(negedge clk);
         end
      end
      if (!errd) begin
         vm[ndx][vw] = 1'b1;
         rr_m = (rr_m + 1) % 4;
      end
      #1;
      check("idle_valid", 128'(valid[ndx][vw]), 128'(!errd));
      check("fault", 128'(fault), 128'(errd));
      check("end_stall", 128'(stall), 128'(0));
      check("end_mem_req", 128'(bus.mem_req), 128'(0));
      @(negedge clk);
      m_apply_pending();
      #1;
      check("fault_clear", 128'(fault), 128'(0));
      check("end_tag_wr", 128'(tag_wr), 128'(0));
      check_valid("post_fill_valid");
   endtask

   // Invalidate in IDLE, optionally together with a miss that must wait a cycle.
   task automatic idle_inv(input int kind, input logic [31:0] adr, input bit with_miss,
                           input logic [31:0] ma);
      inv_all  = (kind == 1);
      inv_line = (kind == 2);
      inv_adr  = adr;
      if (with_miss) begin ip = ma; fetch = 1'b1; ihit = 1'b0; end
      #1;
      check("inv_stall", 128'(stall), 128'(with_miss));
      @(negedge clk);
      inv_all = 1'b0; inv_line = 1'b0;
      if (kind == 1) m_clear_all();
      else m_clear_set(int'(adr[TAGBIT-1:6]));
      #1;
      check("inv_tag_wr", 128'(tag_wr), 128'(0));
      check("inv_mem_req", 128'(bus.mem_req), 128'(0));
      check_valid("inv_valid");
      if (with_miss) run_miss(ma, -1, 1, 0, 32'h0);
      else fetch = 1'b0;
   endtask

   task automatic hit_cycle(input logic [31:0] a);
      ip = a; fetch = 1'b1; ihit = 1'b1;
      #1;
      check("hit_stall", 128'(stall), 128'(0));
      @(negedge clk);
      fetch = 1'b0; ihit = 1'b0;
      #1;
      check("hit_tag_wr", 128'(tag_wr), 128'(0));
      check("hit_mem_req", 128'(bus.mem_req), 128'(0));
   endtask

   function automatic logic [31:0] rand_ip(input logic [7:0] ndx);
      logic [31:0] a;
      a = $urandom;
      a[TAGBIT-1:6] = ndx;
      return a;
   endfunction

   function automatic logic [7:0] pick_ndx();
      case ($urandom_range(3))
         0:       return 8'h10;
         1:       return 8'h11;
         2:       return 8'h49;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      int op;
      int eb;
      int ik;
      n_checks = 0; n_fail = 0;
      rr_m = 0; p_all = 1'b0; p_line = 1'b0; p_ndx = 0;
      m_clear_all();
      rst = 1'b1; ip = '0; fetch = 1'b1; ihit = 1'b0;
      inv_all = 1'b0; inv_line = 1'b0; inv_adr = '0;
      bus.mem_ack = 1'b0; bus.mem_err = 1'b0; bus.mem_dat = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_stall", 128'(stall), 128'(0));
      check("rst_mem_req", 128'(bus.mem_req), 128'(0));
      check("rst_tag_wr", 128'(tag_wr), 128'(0));
      check("rst_fault", 128'(fault), 128'(0));
      check_valid("rst_valid");
      rst = 1'b0; fetch = 1'b0;
      @(negedge clk);

      // First miss into an empty cache, then fill every way of set 0x49
      run_miss(32'h0000_1240, -1, 0, 0, 32'h0);
      check("first_fill_way0", 128'(valid[8'h49][0]), 128'(1));
      run_miss(32'h0001_1240, -1, 0, 0, 32'h0);
      run_miss(32'h0002_1240, -1, 1, 0, 32'h0);
      run_miss(32'h0003_1240, -1, 0, 0, 32'h0);
      // Two more fills elsewhere move the replacement pointer to 2
      run_miss(32'h0000_2080, -1, 0, 0, 32'h0);
      run_miss(32'h0001_2080, -1, 2, 0, 32'h0);
      check("set49_full", 128'(valid[8'h49]), 128'(4'hf));
      run_miss(32'h0004_1240, -1, 0, 0, 32'h0);
      run_miss(32'h0005_1240, -1, 0, 0, 32'h0);
      run_miss(32'h0006_1240, -1, 0, 0, 32'h0);

      // Bus error on beat 2
      run_miss(32'h0000_5540, 2, 0, 0, 32'h0);
      check("err_way_invalid", 128'(valid[8'h55][0]), 128'(0));

      // inv_all during WAIT is deferred and then wipes the fresh line too
      run_miss(32'h0000_3300, -1, 1, 1, 32'h0);
      check("inv_all_wipe", 128'(valid[8'hcc]), 128'(0));

      // inv_line plus miss in the same IDLE cycle
      idle_inv(2, 32'h0000_1240, 1'b1, 32'h0007_1240);

      // Reset in the middle of beat 1
      ip = 32'h0000_0800; fetch = 1'b1; ihit = 1'b0;
      @(negedge clk);
      fetch = 1'b0;
      @(negedge clk);
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      @(negedge clk);
      #2;
      check("pre_rst_mem_req", 128'(bus.mem_req), 128'(1));
      fetch = 1'b1;
      rst = 1'b1;
      #1;
      m_clear_all(); rr_m = 0; p_all = 1'b0; p_line = 1'b0;
      check("async_mem_req", 128'(bus.mem_req), 128'(0));
      check("async_stall", 128'(stall), 128'(0));
      check_valid("async_valid");
      @(negedge clk);
      rst = 1'b0; fetch = 1'b0; bus.mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("post_rst_wr_en", 128'(wr_en), 128'(0));
         check("post_rst_mem_req", 128'(bus.mem_req), 128'(0));
         @(negedge clk);
      end
      bus.mem_ack = 1'b0;
      check_valid("post_rst_valid");

      // Random traffic
      for (int it = 0; it < 150; it++) begin
         op = int'($urandom_range(9));
         if (op <= 4) begin
            eb = ($urandom_range(5) == 0) ? int'($urandom_range(3)) : -1;
            ik = ($urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : 0;
            run_miss(rand_ip(pick_ndx()), eb, int'($urandom_range(2)), ik,
                     rand_ip(pick_ndx()));
         end else if (op <= 6) begin
            hit_cycle(rand_ip(pick_ndx()));
         end else if (op == 7) begin
            idle_inv(int'($urandom_range(2, 1)), rand_ip(pick_ndx()), 1'b0, 32'h0);
         end else if (op == 8) begin
            idle_inv(2, rand_ip(pick_ndx()), 1'b1, rand_ip(pick_ndx()));
         end else begin
            fetch = 1'b0; ihit = 1'b0;
            #1;
            check("nofetch_stall", 128'(stall), 128'(0));
            @(negedge clk);
         end
      end
      check_valid("final_valid");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
